// File: rtl/ternary_neuron_accum_if.sv
// Chunk-beat input stream and single-result output stream of the ternary neuron accumulator.
// The slave side is the accumulator; the master side is the upstream producer plus the result consumer.
interface ternary_neuron_accum_if #(
  parameter int CNT_W = 5,
  parameter int ACC_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [CNT_W-1:0] pos_cnt;
  logic [CNT_W-1:0] neg_cnt;
  logic [ACC_W-1:0] thr_hi;
  logic [ACC_W-1:0] thr_lo;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       act_out;
  logic [ACC_W-1:0] sum_out;
  logic             err_ovf;

  modport master (
    output in_valid, in_last, pos_cnt, neg_cnt, thr_hi, thr_lo, out_ready,
    input  in_ready, out_valid, act_out, sum_out, err_ovf
  );

  modport slave (
    input  in_valid, in_last, pos_cnt, neg_cnt, thr_hi, thr_lo, out_ready,
    output in_ready, out_valid, act_out, sum_out, err_ovf
  );
endinterface

// File: rtl/ternary_neuron_accum.sv
// Accumulates saturating (pos - neg) popcount differences over a multi-chunk neuron and
// thresholds the final signed sum into a ternary activation held in a one-entry output buffer.
module ternary_neuron_accum #(
  parameter int CNT_W      = 5,
  parameter int ACC_W      = 10,
  parameter int MAX_CHUNKS = 16,
  parameter int CHK_W      = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  ternary_neuron_accum_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  localparam logic [1:0]       ACT_POS  = 2'b01;
  localparam logic [1:0]       ACT_NEG  = 2'b11;
  localparam logic [1:0]       ACT_ZERO = 2'b00;
  localparam logic [CHK_W-1:0] CNT_MAX  = CHK_W'(MAX_CHUNKS);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CHK_W-1:0]  cnt_q, cnt_d;
  logic        [1:0]        act_q, act_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;
  logic                     err_q, err_d;

  logic signed [CNT_W:0]    delta;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W-1:0]  s_sat;
  logic                     accept;

  // One guard bit above the accumulator detects overflow; the first beat adds onto zero.
  always_comb begin
    delta    = $signed({1'b0, bus.pos_cnt}) - $signed({1'b0, bus.neg_cnt});
    acc_base = (state_q == S_ACCUM) ? acc_q : '0;
    sum_wide = {acc_base[ACC_W-1], acc_base} + {{(ACC_W-CNT_W){delta[CNT_W]}}, delta};
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      s_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      s_sat = sum_wide[ACC_W-1:0];
    end
  end

  assign accept = bus.in_valid && (state_q != S_OUT);

  // NOTE: every always_comb output gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    sum_d   = sum_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          if (cnt_q == CNT_MAX) err_d = 1'b1;
          if (bus.in_last) begin
            state_d = S_OUT;
            acc_d   = '0;
            cnt_d   = '0;
            sum_d   = s_sat;
            // The +1 test comes first so it wins when thr_lo > thr_hi.
            if (s_sat > $signed(bus.thr_hi))      act_d = ACT_POS;
            else if (s_sat < $signed(bus.thr_lo)) act_d = ACT_NEG;
            else                                  act_d = ACT_ZERO;
          end else begin
            state_d = S_ACCUM;
            acc_d   = s_sat;
            // Holding at the limit keeps over-long neurons from wrapping back below it.
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      act_q   <= ACT_ZERO;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q != S_OUT);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.act_out   = act_q;
  assign bus.sum_out   = sum_q;
  assign bus.err_ovf   = err_q;

endmodule
